// File: rtl/bnn_seq_frontend.sv
// rtl/bnn_seq_frontend.sv - stream sequencer that packs features, starts a BNN core and returns its label
module bnn_seq_frontend #(
  parameter int N   = 11,
  parameter int B   = 4,
  parameter int M   = 40,
  parameter int C   = 6,
  parameter int LAT = N + M,
  parameter int KW  = $clog2(C)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [B-1:0]    in_feat,
  output logic [B*N-1:0]  core_data,
  output logic            core_rst,
  input  logic [KW-1:0]   core_klass,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [KW-1:0]   out_label,
  output logic            out_err,
  output logic [15:0]     frame_cnt
);

  localparam int FW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = $clog2(LAT + 1);
  localparam logic [KW:0] C_EXT = (KW+1)'(C);

  typedef enum logic [1:0] {LOAD, START, RUN, DONE} state_t;

  state_t        state;
  logic [FW-1:0] feat_cnt;
  logic [LW-1:0] lat_cnt;

  // Ready only while collecting features and never during reset, so nothing
  // is accepted on the reset edge itself.
  assign in_ready = (state == LOAD) && !rst;

  // The core is held in reset with the frontend and pulsed for one START cycle.
  assign core_rst = rst || (state == START);

  // Frame sequencer: collect N features, pulse the core, wait LAT, present the label.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      core_data <= '0;
      out_valid <= 1'b0;
      out_label <= '0;
      out_err   <= 1'b0;
      frame_cnt <= '0;
      feat_cnt  <= '0;
      lat_cnt   <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            // Shift left so the first feature ends in the top nibble.
            core_data <= {core_data[B*(N-1)-1:0], in_feat};
            if (feat_cnt == FW'(N - 1)) begin
              feat_cnt <= '0;
              state    <= START;
            end else begin
              feat_cnt <= feat_cnt + 1'b1;
            end
          end
        end
        START: begin
          lat_cnt <= LW'(LAT - 1);
          state   <= RUN;
        end
        RUN: begin
          if (lat_cnt == '0) begin
            // Only this cycle's klass matters; out-of-range classes flag an error.
            if ({1'b0, core_klass} < C_EXT) begin
              out_label <= KW'(C - 1) - core_klass;
              out_err   <= 1'b0;
            end else begin
              out_label <= '0;
              out_err   <= 1'b1;
            end
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_seq_frontend.sv
// tb/tb_bnn_seq_frontend.sv - self-checking bench for bnn_seq_frontend
`timescale 1ns/1ps
module tb_bnn_seq_frontend;
  localparam int N = 11, B = 4, M = 40, C = 6, LAT = 40, KW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, in_valid, in_ready, core_rst, out_valid, out_ready, out_err;
  logic [B-1:0]    in_feat;
  logic [B*N-1:0]  core_data;
  logic [KW-1:0]   core_klass, out_label;
  logic [15:0]     frame_cnt;

  logic            rst1, in_valid1, in_ready1, core_rst1, out_valid1, out_ready1, out_err1;
  logic [B-1:0]    in_feat1;
  logic [B*N-1:0]  core_data1;
  logic [KW-1:0]   core_klass1, out_label1;
  logic [15:0]     frame_cnt1;

  bnn_seq_frontend #(.N(N), .B(B), .M(M), .C(C), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .core_data(core_data), .core_rst(core_rst), .core_klass(core_klass),
    .out_valid(out_valid), .out_ready(out_ready), .out_label(out_label),
    .out_err(out_err), .frame_cnt(frame_cnt));

  bnn_seq_frontend #(.N(N), .B(B), .M(M), .C(C), .LAT(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1), .in_feat(in_feat1),
    .core_data(core_data1), .core_rst(core_rst1), .core_klass(core_klass1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_label(out_label1),
    .out_err(out_err1), .frame_cnt(frame_cnt1));

  typedef struct {
    logic [43:0] data;
    logic [2:0]  klass;
    logic [2:0]  label;
    logic        err;
  } vec_t;

  vec_t tbl[6];
  vec_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endfunction

  // Core model: the right klass appears only in the capture cycle, junk otherwise.
  logic [2:0] tgt = 3'd0;
  int ccyc = 1000;
  always @(posedge clk) begin
    if (core_rst) ccyc <= 0;
    else          ccyc <= ccyc + 1;
  end
  assign core_klass = (ccyc == LAT - 1) ? tgt : ~tgt;

  // Monitor / scoreboard
  int  cyc_n = 0, last_start = 0, exp_frames = 0;
  bit  have_start = 0, per_chk = 0, fc_chk = 0, prev_crst = 0, prev_ov = 0;

  always @(negedge clk) begin
    #2;
    cyc_n++;
    if (!rst) begin
      if (core_rst) begin
        chk("core_rst_single_cycle", 64'(prev_crst), 64'd0);
        if (sb.size() == 0) fail_now("start_without_frame");
        else begin
          chk("core_data_at_start", 64'(core_data), 64'(sb[0].data));
          tgt = sb[0].klass;
        end
        if (per_chk && have_start) chk("frame_period", 64'(cyc_n - last_start), 64'(N + LAT + 2));
        last_start = cyc_n;
        have_start = 1;
      end
      if (out_valid && !prev_ov && have_start)
        chk("out_valid_latency", 64'(cyc_n - last_start), 64'(LAT + 1));
      if (out_valid) begin
        chk("in_ready_in_done", 64'(in_ready), 64'd0);
        if (sb.size() == 0) fail_now("label_without_frame");
        else begin
          chk("out_label", 64'(out_label), 64'(sb[0].label));
          chk("out_err", 64'(out_err), 64'(sb[0].err));
          chk("core_data_held", 64'(core_data), 64'(sb[0].data));
          if (out_ready) begin
            void'(sb.pop_front());
            exp_frames++;
            fc_chk = 1;
          end
        end
      end else if (fc_chk) begin
        chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        fc_chk = 0;
      end
    end
    prev_crst = core_rst && !rst;
    prev_ov   = out_valid;
  end

  task automatic send(int idx, bit gaps, int nf);
    if (nf == N) sb.push_back(tbl[idx]);
    for (int i = 0; i < nf; i++) begin
      bit acc = 0;
      int budget = 0;
      while (!acc) begin
        @(negedge clk);
        if (gaps && $urandom_range(1, 0) == 1) in_valid = 1'b0;
        else begin
          in_valid = 1'b1;
          in_feat  = tbl[idx].data[B*(N-1-i) +: B];
        end
        #1;
        acc = in_valid && in_ready;
        budget++;
        if (budget > 500) begin
          fail_now("feature_accept_timeout");
          return;
        end
      end
    end
  endtask

  task automatic drain();
    int budget = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (sb.size() != 0 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ov();
    int budget = 0;
    do begin
      @(negedge clk);
      #1;
      budget++;
    end while (!out_valid && budget < 300);
    if (!out_valid) fail_now("out_valid_timeout");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    exp_frames = 0;
    fc_chk = 0;
    have_start = 0;
    #1;
    chk("rst_in_ready_low", 64'(in_ready), 64'd0);
    chk("rst_core_rst_high", 64'(core_rst), 64'd1);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_core_data", 64'(core_data), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_core_rst_held", 64'(core_rst), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    chk("core_rst_after_rst", 64'(core_rst), 64'd0);
  endtask

  task automatic lat1_frame(int idx);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      in_valid1   = 1'b1;
      in_feat1    = tbl[idx].data[B*(N-1-i) +: B];
      core_klass1 = ~tbl[idx].klass;
      #1;
      chk("lat1_in_ready", 64'(in_ready1), 64'd1);
    end
    @(negedge clk);
    in_valid1 = 1'b0;
    #1;
    chk("lat1_core_rst", 64'(core_rst1), 64'd1);
    chk("lat1_core_data", 64'(core_data1), 64'(tbl[idx].data));
    @(negedge clk);
    core_klass1 = tbl[idx].klass;
    #1;
    chk("lat1_run_core_rst", 64'(core_rst1), 64'd0);
    chk("lat1_run_no_valid", 64'(out_valid1), 64'd0);
    @(negedge clk);
    core_klass1 = ~tbl[idx].klass;
    out_ready1  = 1'b1;
    #1;
    chk("lat1_out_valid", 64'(out_valid1), 64'd1);
    chk("lat1_out_label", 64'(out_label1), 64'(tbl[idx].label));
    chk("lat1_out_err", 64'(out_err1), 64'(tbl[idx].err));
    chk("lat1_in_ready_done", 64'(in_ready1), 64'd0);
  endtask

  initial begin
    tbl[0] = '{data: 44'h46012229a22, klass: 3'd2, label: 3'd3, err: 1'b0};
    tbl[1] = '{data: 44'h58022538633, klass: 3'd0, label: 3'd5, err: 1'b0};
    tbl[2] = '{data: 44'h57122338733, klass: 3'd5, label: 3'd0, err: 1'b0};
    tbl[3] = '{data: 44'h46012229a22, klass: 3'd7, label: 3'd0, err: 1'b1};
    tbl[4] = '{data: 44'h123456789ab, klass: 3'd1, label: 3'd4, err: 1'b0};
    tbl[5] = '{data: 44'hfedcba98765, klass: 3'd6, label: 3'd0, err: 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_feat = '0; out_ready = 1'b1;
    rst1 = 1'b1; in_valid1 = 1'b0; in_feat1 = '0; out_ready1 = 1'b1; core_klass1 = '0;
    repeat (3) @(negedge clk);
    rst1 = 1'b0;

    do_reset();

    // Each table entry as an isolated frame
    for (int k = 0; k < 6; k++) begin
      send(k, 0, N);
      drain();
    end

    // Back-to-back frames with period check
    do_reset();
    per_chk = 1;
    send(1, 0, N);
    send(2, 0, N);
    drain();
    per_chk = 0;

    // Random input gaps with output stalled in DONE
    fork
      begin
        send(0, 1, N);
        send(4, 1, N);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          out_ready = 1'b0;
          wait_ov();
          repeat (10) @(negedge clk);
          out_ready = 1'b1;
          @(negedge clk);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset mid-load, mid-run and in DONE
    send(2, 0, 6);
    do_reset();
    send(2, 0, N);
    repeat (15) @(negedge clk);
    do_reset();
    out_ready = 1'b0;
    send(4, 0, N);
    wait_ov();
    repeat (3) @(negedge clk);
    do_reset();
    out_ready = 1'b1;
    send(1, 0, N);
    drain();

    // LAT=1 build: two back-to-back frames
    lat1_frame(0);
    lat1_frame(4);
    @(negedge clk);
    out_ready1 = 1'b0;
    #1;
    chk("lat1_frame_cnt", 64'(frame_cnt1), 64'd2);
    chk("lat1_in_ready_next", 64'(in_ready1), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
